// File: rtl/mouse_packet_decoder.sv
// mouse_packet_decoder
// Assembles 3-byte PS/2 mouse packets from a byte-strobe receiver interface.
// Each accepted packet moves a clamped screen cursor and raises a one-cycle
// SendInterrupt. Bad or stalled packets are discarded with a one-cycle
// PacketDropped pulse.
//
// Byte handshake: BYTE_READY is a single-cycle strobe with no back-pressure.
// BYTE_IN and BYTE_ERROR are only meaningful in a cycle where BYTE_READY=1.
// Every strobed byte is consumed, except a byte strobed during UPDATE, which
// is ignored.
module mouse_packet_decoder #(
  parameter int X_MAX          = 160,
  parameter int Y_MAX          = 120,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BYTE_READY,
  input  logic [7:0] BYTE_IN,
  input  logic [1:0] BYTE_ERROR,
  output logic [3:0] MouseStatus,
  output logic [7:0] MouseX,
  output logic [7:0] MouseY,
  output logic       SendInterrupt,
  output logic       PacketDropped,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_DX = 2'd1,
    WAIT_DY = 2'd2,
    UPDATE  = 2'd3
  } state_t;

  // Byte0 fields that matter. Bit 3 is always 1 in an accepted byte0, so it
  // is not stored.
  typedef struct packed {
    logic       y_ovf;   // byte0[7]
    logic       x_ovf;   // byte0[6]
    logic       y_sign;  // byte0[5]
    logic       x_sign;  // byte0[4]
    logic [2:0] btn;     // byte0[2:0] = {M, R, L}
  } hdr_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic signed [10:0] X_TOP      = 11'(X_MAX - 1);
  localparam logic signed [10:0] Y_TOP      = 11'(Y_MAX - 1);
  localparam logic [7:0]        X_HOME      = 8'(X_MAX / 2);
  localparam logic [7:0]        Y_HOME      = 8'(Y_MAX / 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  hdr_t             hdr_q, hdr_d;
  logic [7:0]       dx_q, dx_d;
  logic [7:0]       dy_q, dy_d;
  logic             drop_d;
  logic             byte_ok;

  logic signed [8:0]  dx_s, dy_s;
  logic signed [10:0] x_sum, y_sum;
  logic [7:0]         x_new, y_new;

  assign byte_ok   = (BYTE_ERROR == 2'b00);
  assign fsm_state = state_q;

  // State, timeout counter and packet byte registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= WAIT_B0;
      cnt_q   <= '0;
      hdr_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
    end
  end

  // Next-state, byte capture, timeout and drop decision
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    drop_d  = 1'b0;
    case (state_q)
      WAIT_B0: begin
        cnt_d = '0;
        if (BYTE_READY) begin
          if (byte_ok && BYTE_IN[3]) begin
            hdr_d   = '{y_ovf: BYTE_IN[7], x_ovf: BYTE_IN[6],
                        y_sign: BYTE_IN[5], x_sign: BYTE_IN[4],
                        btn: BYTE_IN[2:0]};
            state_d = WAIT_DX;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      WAIT_DX: begin
        if (BYTE_READY) begin
          // A byte arriving on the timeout cycle still wins.
          cnt_d = '0;
          if (byte_ok) begin
            dx_d    = BYTE_IN;
            state_d = WAIT_DY;
          end else begin
            drop_d  = 1'b1;
            state_d = WAIT_B0;
          end
        end else if (cnt_q == TIMEOUT_LIM) begin
          cnt_d   = '0;
          drop_d  = 1'b1;
          state_d = WAIT_B0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DY: begin
        if (BYTE_READY) begin
          cnt_d = '0;
          if (byte_ok) begin
            dy_d    = BYTE_IN;
            state_d = UPDATE;
          end else begin
            drop_d  = 1'b1;
            state_d = WAIT_B0;
          end
        end else if (cnt_q == TIMEOUT_LIM) begin
          cnt_d   = '0;
          drop_d  = 1'b1;
          state_d = WAIT_B0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      UPDATE: begin
        // Single cycle; any strobe here is ignored.
        cnt_d   = '0;
        state_d = WAIT_B0;
      end
      default: begin
        state_d = WAIT_B0;
        cnt_d   = '0;
      end
    endcase
  end

  // Signed movement with overflow saturation, then clamp to the screen
  always_comb begin
    if (hdr_q.x_ovf) dx_s = hdr_q.x_sign ? 9'sh100 : 9'sh0FF;
    else             dx_s = $signed({hdr_q.x_sign, dx_q});
    if (hdr_q.y_ovf) dy_s = hdr_q.y_sign ? 9'sh100 : 9'sh0FF;
    else             dy_s = $signed({hdr_q.y_sign, dy_q});

    // PS/2 positive dy is up; screen row 0 is the top, so Y subtracts.
    x_sum = $signed({3'b000, MouseX}) + $signed({{2{dx_s[8]}}, dx_s});
    y_sum = $signed({3'b000, MouseY}) - $signed({{2{dy_s[8]}}, dy_s});

    if (x_sum < 11'sd0)      x_new = 8'd0;
    else if (x_sum > X_TOP)  x_new = X_TOP[7:0];
    else                     x_new = x_sum[7:0];

    if (y_sum < 11'sd0)      y_new = 8'd0;
    else if (y_sum > Y_TOP)  y_new = Y_TOP[7:0];
    else                     y_new = y_sum[7:0];
  end

  // Registered outputs: commit on the edge leaving UPDATE, pulses for one cycle
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MouseX        <= X_HOME;
      MouseY        <= Y_HOME;
      MouseStatus   <= 4'h0;
      SendInterrupt <= 1'b0;
      PacketDropped <= 1'b0;
    end else begin
      SendInterrupt <= (state_q == UPDATE);
      PacketDropped <= drop_d;
      if (state_q == UPDATE) begin
        MouseX      <= x_new;
        MouseY      <= y_new;
        MouseStatus <= {hdr_q.x_ovf | hdr_q.y_ovf, hdr_q.btn};
      end
    end
  end

endmodule
